// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//   Read-side controller for a sync_fifo with registered read data (one-cycle
//   latency). It pops words from the FIFO and presents them on a valid/ready
//   stream through a 2-entry skid buffer. It sustains one word per clock and
//   never pops an empty FIFO.
//
// Ports
//   clk_i         in   clock, rising edge
//   rst_ni        in   asynchronous active-low reset
//   enable_i      in   1 = issue FIFO reads; 0 = stop issuing, keep draining
//   fifo_empty_i  in   FIFO empty flag
//   fifo_rdata_i  in   FIFO read data, valid the cycle after a sampled pop
//   fifo_rd_en_o  out  FIFO pop request (combinational)
//   m_valid_o     out  stream word valid
//   m_ready_i     in   stream consumer ready
//   m_data_o      out  stream data (head slot)
//   word_cnt_o    out  count of delivered words, wraps modulo 2^COUNT_W
//   busy_o        out  a word is buffered or in flight
module fifo_stream_reader #(
  parameter int WIDTH   = 4,
  parameter int COUNT_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               enable_i,
  input  logic               fifo_empty_i,
  input  logic [WIDTH-1:0]   fifo_rdata_i,
  output logic               fifo_rd_en_o,
  output logic               m_valid_o,
  input  logic               m_ready_i,
  output logic [WIDTH-1:0]   m_data_o,
  output logic [COUNT_W-1:0] word_cnt_o,
  output logic               busy_o
);

  logic [WIDTH-1:0]   head_reg, head_next;
  logic [WIDTH-1:0]   tail_reg, tail_next;
  logic [1:0]         occ_reg, occ_next;
  logic               inflight_reg;
  logic [COUNT_W-1:0] cnt_reg;

  logic               pop;
  logic [2:0]         level;
  logic               room;
  logic [1:0]         retained;

  assign pop = m_valid_o & m_ready_i;

  // Occupancy after this edge if nothing new is requested; a pop can only
  // happen with occ >= 1, so the subtraction never underflows.
  assign level = {1'b0, occ_reg} + {2'b00, inflight_reg} - {2'b00, pop};
  assign room  = (level < 3'd2);

  // Gated by reset so no pop is issued while the buffer state is held clear;
  // a word popped then would have nowhere to land.
  assign fifo_rd_en_o = rst_ni & enable_i & ~fifo_empty_i & room;

  // Words surviving this edge's pop.
  assign retained = occ_reg - {1'b0, pop};

  always_comb begin
    head_next = head_reg;
    tail_next = tail_reg;
    occ_next  = level[1:0];
    if (pop) begin
      head_next = tail_reg;
    end
    // The captured word goes directly behind whatever is retained.
    if (inflight_reg) begin
      if (retained == 2'd0) begin
        head_next = fifo_rdata_i;
      end else begin
        tail_next = fifo_rdata_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      occ_reg      <= 2'd0;
      inflight_reg <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      occ_reg      <= occ_next;
      inflight_reg <= fifo_rd_en_o;
      if (pop) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign m_valid_o  = (occ_reg != 2'd0);
  assign m_data_o   = head_reg;
  assign word_cnt_o = cnt_reg;
  assign busy_o     = (occ_reg != 2'd0) | inflight_reg;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader
//   Directed bench for fifo_stream_reader. A behavioural FIFO (registered read
//   data) feeds the reader; every valid output word is compared against the
//   next unread word the bench pushed. A second instance with a 4-bit counter
//   shares the same inputs and is used for the counter wrap case.
module tb_fifo_stream_reader;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        enable_i = 1'b0;
  logic        m_ready_i = 1'b0;
  logic        fifo_empty_i;
  logic [3:0]  fifo_rdata_i = 4'd0;
  logic        fifo_rd_en_o;
  logic        m_valid_o;
  logic [3:0]  m_data_o;
  logic [15:0] word_cnt_o;
  logic        busy_o;

  logic        rd_en_w;
  logic        valid_w;
  logic [3:0]  data_w;
  logic [3:0]  cnt_w;
  logic        busy_w;

  logic [3:0]  mem [0:255];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          exp_idx = 0;
  int          delivered = 0;
  int          pops = 0;
  int          underflow = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk_i = ~clk_i;

  fifo_stream_reader #(.WIDTH(4), .COUNT_W(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i),
    .fifo_empty_i(fifo_empty_i), .fifo_rdata_i(fifo_rdata_i),
    .fifo_rd_en_o(fifo_rd_en_o), .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .word_cnt_o(word_cnt_o), .busy_o(busy_o)
  );

  fifo_stream_reader #(.WIDTH(4), .COUNT_W(4)) dut_w (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i),
    .fifo_empty_i(fifo_empty_i), .fifo_rdata_i(fifo_rdata_i),
    .fifo_rd_en_o(rd_en_w), .m_valid_o(valid_w),
    .m_ready_i(m_ready_i), .m_data_o(data_w),
    .word_cnt_o(cnt_w), .busy_o(busy_w)
  );

  // Behavioural sync FIFO, one-cycle registered read.
  assign fifo_empty_i = (rd_ptr == wr_ptr);

  always @(posedge clk_i) begin
    if (fifo_rd_en_o) begin
      fifo_rdata_i <= mem[rd_ptr[7:0]];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [3:0] v);
    mem[wr_ptr[7:0]] = v;
    wr_ptr++;
  endtask

  // Monitor samples just before each rising edge, after inputs have settled.
  always @(negedge clk_i) begin
    #4;
    if (!rst_ni) begin
      exp_idx = rd_ptr;
    end else begin
      if (fifo_rd_en_o) pops++;
      if (fifo_rd_en_o && fifo_empty_i) underflow++;
      if (m_valid_o) chk("data", {28'd0, m_data_o}, {28'd0, mem[exp_idx[7:0]]});
      if (m_valid_o && m_ready_i) begin
        $display("word %0d data=%h cnt=%0d", delivered, m_data_o, word_cnt_o);
        exp_idx++;
        delivered++;
      end
    end
  end

  logic [3:0] t3_words [0:4];
  int         del0;
  int         pops0;
  bit         done;

  initial begin
    t3_words[0] = 4'hA; t3_words[1] = 4'h5; t3_words[2] = 4'hC;
    t3_words[3] = 4'h3; t3_words[4] = 4'h9;

    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_valid", {31'd0, m_valid_o}, 0);
    chk("rst_busy",  {31'd0, busy_o}, 0);
    chk("rst_rd_en", {31'd0, fifo_rd_en_o}, 0);
    chk("rst_cnt",   {16'd0, word_cnt_o}, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // T2: stream 0..15 with ready high
    @(negedge clk_i);
    del0 = delivered;
    for (int i = 0; i < 16; i++) push(i[3:0]);
    enable_i  = 1'b1;
    m_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("t2_first_valid", {31'd0, m_valid_o}, 1);
    chk("t2_first_data",  {28'd0, m_data_o}, 0);
    repeat (16) @(negedge clk_i);
    chk("t2_delivered", delivered - del0, 16);
    chk("t2_cnt",       {16'd0, word_cnt_o}, 16);
    chk("t2_idle",      {31'd0, busy_o}, 0);
    chk("t2_cnt_w",     {28'd0, cnt_w}, 0);
    repeat (2) @(negedge clk_i);
    chk("t2_underflow", underflow, 0);

    // T6: one more word -> 17 total, 4-bit counter reads 1
    push(4'h7);
    repeat (4) @(negedge clk_i);
    chk("t6_cnt",   {16'd0, word_cnt_o}, 17);
    chk("t6_cnt_w", {28'd0, cnt_w}, 1);

    // T3: backpressure
    m_ready_i = 1'b0;
    pops0 = pops;
    del0  = delivered;
    for (int i = 0; i < 5; i++) push(t3_words[i]);
    repeat (10) @(negedge clk_i);
    chk("t3_pops",  pops - pops0, 2);
    chk("t3_valid", {31'd0, m_valid_o}, 1);
    chk("t3_hold",  {28'd0, m_data_o}, {28'd0, t3_words[0]});
    #1;
    chk("t3_rd_en", {31'd0, fifo_rd_en_o}, 0);
    @(negedge clk_i);
    m_ready_i = 1'b1;
    repeat (8) @(negedge clk_i);
    chk("t3_delivered", delivered - del0, 5);
    chk("t3_cnt", {16'd0, word_cnt_o}, 22);

    // T1: reset with a full buffer
    m_ready_i = 1'b0;
    push(4'h1); push(4'h2); push(4'h3); push(4'h4);
    repeat (6) @(negedge clk_i);
    chk("t1_full_busy", {31'd0, busy_o}, 1);
    rst_ni = 1'b0;
    #1;
    chk("t1_valid", {31'd0, m_valid_o}, 0);
    chk("t1_data",  {28'd0, m_data_o}, 0);
    chk("t1_cnt",   {16'd0, word_cnt_o}, 0);
    chk("t1_busy",  {31'd0, busy_o}, 0);
    chk("t1_rd_en", {31'd0, fifo_rd_en_o}, 0);
    @(negedge clk_i);
    rst_ni    = 1'b1;
    m_ready_i = 1'b1;
    del0      = delivered;
    repeat (6) @(negedge clk_i);
    chk("t1_delivered", delivered - del0, 2);
    chk("t1_cnt_after", {16'd0, word_cnt_o}, 2);

    // T4: random ready, 200 random words, from a clean reset
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    del0 = delivered;
    for (int i = 0; i < 200; i++) push($urandom_range(0, 15));
    done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk_i);
      m_ready_i = ($urandom_range(0, 1) == 1);
      if (delivered - del0 == 200) done = 1'b1;
    end
    m_ready_i = 1'b1;
    chk("t4_done", {31'd0, done}, 1);
    chk("t4_cnt", {16'd0, word_cnt_o}, 200);
    chk("t4_cnt_w", {28'd0, cnt_w}, 8);

    // T5: drop enable for 8 cycles while streaming
    @(negedge clk_i);
    del0 = delivered;
    for (int i = 0; i < 20; i++) push(i[3:0] ^ 4'h5);
    repeat (5) @(negedge clk_i);
    enable_i = 1'b0;
    #1;
    chk("t5_stop", {31'd0, fifo_rd_en_o}, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      #1;
      chk("t5_hold_off", {31'd0, fifo_rd_en_o}, 0);
    end
    chk("t5_drained", {31'd0, busy_o}, 0);
    enable_i = 1'b1;
    repeat (30) @(negedge clk_i);
    chk("t5_delivered", delivered - del0, 20);
    chk("t5_cnt", {16'd0, word_cnt_o}, 220);
    chk("underflow", underflow, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
